except_ctrl: RTL

EXCEPT_CTRL -- requirements
Module: except_ctrl

---
 rtl/except_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/except_ctrl.sv
// Exception/interrupt arbiter for the MEM stage: picks the highest-priority cause, hands it to CP0
// in the take cycle, then holds a registered flush and redirect PC for FLUSH_CYCLES cycles.
module except_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h00000040,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delay_slot,
    input  logic        exc_syscall,
    input  logic        exc_ri,
    input  logic        exc_ov,
    input  logic        exc_tr,
    input  logic        exc_eret,
    input  logic        time_int_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we,
    input  logic [4:0]  wb_cp0_waddr,
    input  logic [31:0] wb_cp0_data,
    input  logic        stall_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] cp0_pc_o,
    output logic        cp0_in_delay_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [4:0] CODE_NONE = 5'h00;
    localparam logic [4:0] CODE_INT  = 5'h01;
    localparam logic [4:0] CODE_SYS  = 5'h09;
    localparam logic [4:0] CODE_RI   = 5'h0a;
    localparam logic [4:0] CODE_OV   = 5'h0b;
    localparam logic [4:0] CODE_TR   = 5'h0c;
    localparam logic [4:0] CODE_ERET = 5'h0d;
    localparam logic [3:0] CNT_INIT  = 4'(FLUSH_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        exl_shadow;
    logic [31:0] new_pc_q;

    logic [31:0] eff_status, eff_cause, eff_epc;
    logic [7:0]  pend_ip;
    logic        int_req;
    logic [4:0]  code;
    logic        take;
    logic        is_eret;
    logic        unused_bits;

    // An MTC0 still in WB has not reached CP0 yet, so its data wins over the stale register value.
    assign eff_status = (wb_cp0_we && wb_cp0_waddr == 5'd12) ? wb_cp0_data : cp0_status_i;
    assign eff_cause  = (wb_cp0_we && wb_cp0_waddr == 5'd13) ? wb_cp0_data : cp0_cause_i;
    assign eff_epc    = (wb_cp0_we && wb_cp0_waddr == 5'd14) ? wb_cp0_data : cp0_epc_i;

    assign pend_ip = eff_cause[15:8] | {time_int_i, 7'b0};
    assign int_req = (|(pend_ip & eff_status[15:8])) && eff_status[0] && !eff_status[1]
                     && !exl_shadow;

    always_comb begin
        code = CODE_NONE;
        if (int_req)          code = CODE_INT;
        else if (exc_ri)      code = CODE_RI;
        else if (exc_ov)      code = CODE_OV;
        else if (exc_tr)      code = CODE_TR;
        else if (exc_syscall) code = CODE_SYS;
        else if (exc_eret)    code = CODE_ERET;
    end

    assign take    = !reset && (state == IDLE) && mem_valid && !stall_i && (code != CODE_NONE);
    assign is_eret = (code == CODE_ERET);

    // CP0 commits on the take edge, so these are deliberately combinational.
    assign excepttype_o   = take ? {27'b0, code} : 32'b0;
    assign cp0_pc_o       = take ? mem_pc : 32'b0;
    assign cp0_in_delay_o = take && mem_in_delay_slot;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = CNT_INIT;
                end
            end
            FLUSH: begin
                if (cnt == 4'd0) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            exl_shadow <= 1'b0;
            new_pc_q   <= 32'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (take) begin
                exl_shadow <= !is_eret;
                new_pc_q   <= is_eret ? eff_epc : EXC_VECTOR;
            end
        end
    end

    assign flush_o  = (state == FLUSH);
    assign busy_o   = (state != IDLE);
    assign new_pc_o = new_pc_q;

    assign unused_bits = ^{eff_status[31:16], eff_status[7:2], eff_cause[31:16], eff_cause[7:0]};

endmodule
